// File: rtl/wd_bus_sequencer_pkg.sv
// wd_pkg: shared constants, address codes, idle bus values and FSM state type
// for the watchdog bus sequencer.
package wd_pkg;
    localparam logic [7:0] UNLOCK_A   = 8'hAA;
    localparam logic [7:0] UNLOCK_B   = 8'h55;
    localparam logic [1:0] ADDR_FRAME = 2'b00;
    localparam logic [1:0] ADDR_SVC   = 2'b01;
    localparam logic [1:0] ADDR_INIT  = 2'b10;
    localparam logic [1:0] ADDR_LIMIT = 2'b11;
    localparam logic [1:0] ABUS_IDLE  = ADDR_INIT;
    localparam logic [7:0] DBUS_IDLE  = 8'h00;
    typedef enum logic [2:0] {S_IDLE, S_UNLK_A, S_GAP, S_UNLK_B, S_WRITE} state_t;
endpackage

// File: rtl/wd_bus_sequencer_if.sv
// wd_bus_sequencer_if: watchdog write port.
//   ABUS   2-bit address bus, driven by the sequencer (master)
//   DBUS   8-bit data bus, driven by the sequencer (master)
//   WDFAIL fail flag, driven by the watchdog (slave)
interface wd_bus_sequencer_if;
    logic [1:0] ABUS;
    logic [7:0] DBUS;
    logic       WDFAIL;
    modport master (output ABUS, output DBUS, input WDFAIL);
    modport slave  (input ABUS, input DBUS, output WDFAIL);
endinterface

// File: rtl/wd_bus_sequencer_auto_timer.sv
// wd_auto_timer: auto-service down-counter that flags when a kick is due.
//   CLK/RST  clock, asynchronous active-low reset
//   en       timer enable
//   period   interval in cycles, 0 disables
//   reload   restart the interval (transaction completion)
//   expire   high while the count sits at 1 (one cycle per interval)
module wd_auto_timer #(
    parameter int unsigned PERIOD_W = 16
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                en,
    input  logic [PERIOD_W-1:0] period,
    input  logic                reload,
    output logic                expire
);
    logic [PERIOD_W-1:0] cnt;
    logic                active;
    assign active = en && (period != '0);
    // Expiry is decided from the count alone, so a coincident reload cannot mask it.
    assign expire = active && (cnt == PERIOD_W'(1));
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) cnt <= '0;
        else cnt <= (!active || reload || cnt <= PERIOD_W'(1)) ? period : cnt - PERIOD_W'(1);
    end
endmodule

// File: rtl/wd_bus_sequencer.sv
// wd_bus_sequencer: sole master of the watchdog write bus; serialises config
// loads and service kicks into the unlock + 4-beat write-window protocol.
//   CLK/RST      clock, asynchronous active-low reset
//   CFG_START    config load request; CFG_FRAME/SVC/LIMIT values to load
//   KICK_REQ     manual service request
//   AUTO_EN      auto-service enable; AUTO_PERIOD interval (0 = off)
//   bus          ABUS/DBUS out, WDFAIL in
//   BUSY         transaction in progress
//   CFG_DONE     config transaction complete pulse
//   KICK_DONE    kick transaction complete pulse
//   FAIL_SEEN    sticky WDFAIL, cleared when a config is accepted
module wd_bus_sequencer
    import wd_pkg::*;
#(
    parameter int unsigned UNLOCK_GAP = 2,
    parameter logic [7:0]  KICK_CODE  = 8'h08,
    parameter int unsigned PERIOD_W   = 16
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 CFG_START,
    input  logic [7:0]           CFG_FRAME,
    input  logic [7:0]           CFG_SVC,
    input  logic [7:0]           CFG_LIMIT,
    input  logic                 KICK_REQ,
    input  logic                 AUTO_EN,
    input  logic [PERIOD_W-1:0]  AUTO_PERIOD,
    wd_bus_sequencer_if.master   bus,
    output logic                 BUSY,
    output logic                 CFG_DONE,
    output logic                 KICK_DONE,
    output logic                 FAIL_SEEN
);
    localparam logic [3:0] GAP_LAST = 4'(UNLOCK_GAP == 0 ? 0 : UNLOCK_GAP - 1);
    state_t     state;
    logic [3:0] gap_cnt;
    logic [1:0] beat, nb;
    logic       is_cfg, cfg_pend, kick_pend;
    logic [7:0] frame_q, svc_q, limit_q;
    logic [1:0] abus;
    logic [7:0] dbus;
    logic       acc, acc_cfg, completing, expire;
    logic [1:0] wr_abus;
    logic [7:0] wr_dbus;
    assign bus.ABUS = abus;
    assign bus.DBUS = dbus;
    assign acc        = (state == S_IDLE) && (cfg_pend || kick_pend);
    assign acc_cfg    = acc && cfg_pend;
    assign completing = (state == S_WRITE) && (beat == 2'd3);
    // Bus value for the write beat that the next edge will present.
    always_comb begin
        nb = (state == S_WRITE) ? beat + 2'd1 : 2'd0;
        wr_abus = !is_cfg ? ADDR_INIT :
                  nb == 2'd0 ? ADDR_FRAME : nb == 2'd1 ? ADDR_SVC :
                  nb == 2'd2 ? ADDR_LIMIT : ADDR_INIT;
        wr_dbus = !is_cfg ? (nb == 2'd0 ? KICK_CODE : 8'h00) :
                  nb == 2'd0 ? frame_q : nb == 2'd1 ? svc_q :
                  nb == 2'd2 ? limit_q : 8'h00;
    end
    // Reload on the completion edge itself so the next interval starts with the idle cycle.
    wd_auto_timer #(.PERIOD_W(PERIOD_W)) u_timer (
        .CLK    (CLK),
        .RST    (RST),
        .en     (AUTO_EN),
        .period (AUTO_PERIOD),
        .reload (completing),
        .expire (expire)
    );
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state     <= S_IDLE;
            gap_cnt   <= '0;
            beat      <= '0;
            is_cfg    <= 1'b0;
            cfg_pend  <= 1'b0;
            kick_pend <= 1'b0;
            frame_q   <= '0;
            svc_q     <= '0;
            limit_q   <= '0;
            abus      <= ABUS_IDLE;
            dbus      <= DBUS_IDLE;
            BUSY      <= 1'b0;
            CFG_DONE  <= 1'b0;
            KICK_DONE <= 1'b0;
            FAIL_SEEN <= 1'b0;
        end else begin
            // New requests win over the clear so a request at acceptance is not lost.
            cfg_pend  <= CFG_START | (cfg_pend & ~acc_cfg);
            kick_pend <= KICK_REQ | expire | (kick_pend & ~(acc & ~cfg_pend));
            FAIL_SEEN <= bus.WDFAIL | (FAIL_SEEN & ~acc_cfg);
            CFG_DONE  <= 1'b0;
            KICK_DONE <= 1'b0;
            case (state)
                S_IDLE: if (acc) begin
                    state  <= S_UNLK_A;
                    is_cfg <= cfg_pend;
                    abus   <= ADDR_FRAME;
                    dbus   <= UNLOCK_A;
                    BUSY   <= 1'b1;
                    if (cfg_pend) begin
                        frame_q <= CFG_FRAME;
                        svc_q   <= CFG_SVC;
                        limit_q <= CFG_LIMIT;
                    end
                end
                S_UNLK_A: begin
                    gap_cnt <= '0;
                    state   <= (UNLOCK_GAP == 0) ? S_UNLK_B : S_GAP;
                    dbus    <= (UNLOCK_GAP == 0) ? UNLOCK_B : 8'h00;
                end
                S_GAP: if (gap_cnt == GAP_LAST) begin
                    state <= S_UNLK_B;
                    dbus  <= UNLOCK_B;
                end else begin
                    gap_cnt <= gap_cnt + 4'd1;
                end
                S_UNLK_B: begin
                    state <= S_WRITE;
                    beat  <= 2'd0;
                    abus  <= wr_abus;
                    dbus  <= wr_dbus;
                end
                S_WRITE: begin
                    beat <= nb;
                    abus <= completing ? ABUS_IDLE : wr_abus;
                    dbus <= completing ? DBUS_IDLE : wr_dbus;
                    if (completing) begin
                        state     <= S_IDLE;
                        BUSY      <= 1'b0;
                        CFG_DONE  <= is_cfg;
                        KICK_DONE <= !is_cfg;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_wd_bus_sequencer.sv
// tb_wd_bus_sequencer: directed self-checking bench for wd_bus_sequencer.
module tb_wd_bus_sequencer;
    logic        CLK = 1'b0, RST = 1'b1;
    logic        CFG_START = 1'b0, KICK_REQ = 1'b0, AUTO_EN = 1'b0;
    logic [7:0]  CFG_FRAME = '0, CFG_SVC = '0, CFG_LIMIT = '0;
    logic [15:0] AUTO_PERIOD = '0;
    logic        BUSY, CFG_DONE, KICK_DONE, FAIL_SEEN;
    int          n_cmp = 0, n_err = 0;
    int          t_start[3];
    int          ns;
    logic        pb;
    wd_bus_sequencer_if bus();
    wd_bus_sequencer dut (
        .CLK         (CLK),
        .RST         (RST),
        .CFG_START   (CFG_START),
        .CFG_FRAME   (CFG_FRAME),
        .CFG_SVC     (CFG_SVC),
        .CFG_LIMIT   (CFG_LIMIT),
        .KICK_REQ    (KICK_REQ),
        .AUTO_EN     (AUTO_EN),
        .AUTO_PERIOD (AUTO_PERIOD),
        .bus         (bus),
        .BUSY        (BUSY),
        .CFG_DONE    (CFG_DONE),
        .KICK_DONE   (KICK_DONE),
        .FAIL_SEEN   (FAIL_SEEN)
    );
    always #5 CLK = ~CLK;
    task automatic step();
        @(posedge CLK);
        #1;
    endtask
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    function automatic logic [9:0] exp_beat(input bit c, input logic [7:0] f, s, l, input int i);
        case (i)
            0:       return {2'b00, 8'hAA};
            1, 2:    return {2'b00, 8'h00};
            3:       return {2'b00, 8'h55};
            4:       return c ? {2'b00, f} : {2'b10, 8'h08};
            5:       return c ? {2'b01, s} : {2'b10, 8'h00};
            6:       return c ? {2'b11, l} : {2'b10, 8'h00};
            default: return {2'b10, 8'h00};
        endcase
    endfunction
    // Checks beats first..7 (one per step), then the completion cycle.
    task automatic run_txn(input bit c, input logic [7:0] f, s, l, input int first, input string tag);
        for (int i = first; i < 8; i++) begin
            step();
            chk($sformatf("%s_bus%0d", tag, i), {22'd0, bus.ABUS, bus.DBUS}, {22'd0, exp_beat(c, f, s, l, i)});
            chk($sformatf("%s_busy%0d", tag, i), BUSY, 1);
        end
        step();
        chk({tag, "_idle_bus"}, {22'd0, bus.ABUS, bus.DBUS}, 32'h200);
        chk({tag, "_busy_low"}, BUSY, 0);
        chk({tag, "_cfg_done"}, CFG_DONE, c);
        chk({tag, "_kick_done"}, KICK_DONE, !c);
    endtask
    task automatic count_starts(input string tag);
        repeat (30) step();
        ns = 0;
        pb = BUSY;
        for (int c = 0; c < 100; c++) begin
            step();
            if (BUSY && !pb) ns++;
            pb = BUSY;
        end
        chk(tag, ns, 0);
    endtask
    initial begin
        bus.WDFAIL = 1'b0;
        #1 RST = 1'b0;
        #1;
        chk("rst_bus", {22'd0, bus.ABUS, bus.DBUS}, 32'h200);
        chk("rst_busy", BUSY, 0);
        chk("rst_cfg_done", CFG_DONE, 0);
        chk("rst_kick_done", KICK_DONE, 0);
        chk("rst_fail_seen", FAIL_SEEN, 0);
        repeat (2) @(posedge CLK);
        #1 RST = 1'b1;
        step();
        // config load; inputs change after acceptance and must be ignored
        CFG_START = 1'b1; CFG_FRAME = 8'h0A; CFG_SVC = 8'h03; CFG_LIMIT = 8'h04;
        step();
        CFG_START = 1'b0;
        chk("cfg_pending_idle", {22'd0, bus.ABUS, bus.DBUS}, 32'h200);
        step();
        chk("cfg_bus0", {22'd0, bus.ABUS, bus.DBUS}, 32'h0AA);
        chk("cfg_busy0", BUSY, 1);
        CFG_FRAME = 8'hFF; CFG_SVC = 8'hFF; CFG_LIMIT = 8'hFF;
        run_txn(1'b1, 8'h0A, 8'h03, 8'h04, 1, "cfg");
        step();
        chk("cfg_done_pulse", CFG_DONE, 0);
        // manual kick
        KICK_REQ = 1'b1;
        step();
        KICK_REQ = 1'b0;
        chk("kick_pending_busy", BUSY, 0);
        run_txn(1'b0, 8'h00, 8'h00, 8'h00, 0, "kick");
        step();
        chk("kick_done_pulse", KICK_DONE, 0);
        // simultaneous requests: cfg first, kick after one idle cycle
        CFG_START = 1'b1; KICK_REQ = 1'b1;
        CFG_FRAME = 8'h11; CFG_SVC = 8'h22; CFG_LIMIT = 8'h33;
        step();
        CFG_START = 1'b0; KICK_REQ = 1'b0;
        run_txn(1'b1, 8'h11, 8'h22, 8'h33, 0, "sim_cfg");
        run_txn(1'b0, 8'h00, 8'h00, 8'h00, 0, "sim_kick");
        step();
        chk("sim_after_busy", BUSY, 0);
        // fail flag is sticky until a cfg is accepted
        bus.WDFAIL = 1'b1;
        step();
        bus.WDFAIL = 1'b0;
        chk("fail_set", FAIL_SEEN, 1);
        repeat (5) step();
        chk("fail_sticky", FAIL_SEEN, 1);
        CFG_START = 1'b1; CFG_FRAME = 8'h21; CFG_SVC = 8'h42; CFG_LIMIT = 8'h63;
        step();
        CFG_START = 1'b0;
        chk("fail_before_accept", FAIL_SEEN, 1);
        step();
        chk("fail_cleared", FAIL_SEEN, 0);
        run_txn(1'b1, 8'h21, 8'h42, 8'h63, 1, "clr_cfg");
        CFG_START = 1'b1;
        step();
        CFG_START = 1'b0;
        bus.WDFAIL = 1'b1;
        step();
        bus.WDFAIL = 1'b0;
        chk("fail_coincide", FAIL_SEEN, 1);
        run_txn(1'b1, 8'h21, 8'h42, 8'h63, 1, "coin_cfg");
        // reset during WRITE beat 2
        CFG_START = 1'b1; CFG_FRAME = 8'h5A; CFG_SVC = 8'hA5; CFG_LIMIT = 8'h3C;
        step();
        CFG_START = 1'b0;
        for (int i = 0; i < 7; i++) begin
            step();
            chk($sformatf("pre_rst_bus%0d", i), {22'd0, bus.ABUS, bus.DBUS}, {22'd0, exp_beat(1'b1, 8'h5A, 8'hA5, 8'h3C, i)});
        end
        chk("pre_rst_fail", FAIL_SEEN, 0);
        #2 RST = 1'b0;
        #1;
        chk("async_rst_bus", {22'd0, bus.ABUS, bus.DBUS}, 32'h200);
        chk("async_rst_busy", BUSY, 0);
        #3 RST = 1'b1;
        ns = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (CFG_DONE || BUSY) ns++;
        end
        chk("no_resume", ns, 0);
        // auto-service
        AUTO_PERIOD = 16'd20;
        AUTO_EN = 1'b1;
        ns = 0;
        pb = BUSY;
        t_start = '{0, 0, 0};
        for (int c = 0; c < 200 && ns < 3; c++) begin
            step();
            if (BUSY && !pb) begin
                t_start[ns] = c;
                ns++;
            end
            pb = BUSY;
        end
        chk("auto_starts", ns, 3);
        chk("auto_interval1", t_start[1] - t_start[0], 29);
        chk("auto_interval2", t_start[2] - t_start[1], 29);
        AUTO_EN = 1'b0;
        count_starts("auto_en_off");
        AUTO_EN = 1'b1;
        AUTO_PERIOD = 16'd0;
        count_starts("auto_period_zero");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
